// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit: bus widths, FSM state
// encodings, handshake constants and small arithmetic helpers.
package div_unit_pkg;

    localparam int RegBusWidth       = 32;
    localparam int DoubleRegBusWidth = 64;

    typedef logic [RegBusWidth-1:0]       reg_bus_t;
    typedef logic [DoubleRegBusWidth-1:0] double_reg_bus_t;

    // Divider FSM state encodings
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Start request levels driven by EX
    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    // Result-valid levels returned to EX
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // One quotient bit per iteration
    localparam logic [5:0] DivIterations = 6'd32;

    // Operand attributes captured when a divide is accepted
    typedef struct packed {
        logic signed_mode;
        logic dividend_neg;
        logic divisor_neg;
    } div_sign_t;

    // Two's-complement negation at register width
    function automatic reg_bus_t negate(input reg_bus_t x);
        return ~x + 32'd1;
    endfunction

    // Magnitude of an operand; 0x80000000 maps onto itself and is then
    // treated as an unsigned value by the datapath
    function automatic reg_bus_t magnitude(input reg_bus_t x, input logic signed_mode);
        return (signed_mode && x[RegBusWidth-1]) ? negate(x) : x;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider handshake bundle. EX owns the request side (master), the
// divider owns the result side (slave).
interface div_if;
    import div_unit_pkg::*;

    logic            signed_div_i;
    reg_bus_t        opdata1_i;
    reg_bus_t        opdata2_i;
    logic            start_i;
    logic            annul_i;
    double_reg_bus_t result_o;
    logic            ready_o;

    // Execute stage: issues operands and the start/annul controls
    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    // Divider: consumes the request, returns {remainder, quotient}
    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );

endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU. Produces one quotient bit per cycle
// on operand magnitudes, then applies sign correction for signed mode so the
// quotient truncates toward zero and the remainder follows the dividend sign.
// Result layout is {remainder, quotient}; all outputs are registered.
module div_unit
    import div_unit_pkg::*;
(
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    div_state_e      state_q,   state_d;
    logic [5:0]      cnt_q,     cnt_d;
    logic [64:0]     work_q,    work_d;
    reg_bus_t        divisor_q, divisor_d;
    div_sign_t       sign_q,    sign_d;
    double_reg_bus_t result_q,  result_d;
    logic            ready_q,   ready_d;

    logic [32:0]     trial;
    reg_bus_t        quotient_mag;
    reg_bus_t        remainder_mag;
    reg_bus_t        quotient_fix;
    reg_bus_t        remainder_fix;
    logic            accept;

    // Trial subtraction at 33 bits so bit 32 is the borrow (negative result)
    assign trial = {1'b0, work_q[63:32]} - {1'b0, divisor_q};

    // Raw results after the last iteration, then signed-mode correction
    assign quotient_mag  = work_q[31:0];
    assign remainder_mag = work_q[64:33];
    assign quotient_fix  = (sign_q.signed_mode && (sign_q.dividend_neg ^ sign_q.divisor_neg))
                           ? negate(quotient_mag) : quotient_mag;
    assign remainder_fix = (sign_q.signed_mode && sign_q.dividend_neg)
                           ? negate(remainder_mag) : remainder_mag;

    // A request is taken only when not being flushed in the same cycle
    assign accept = (bus.start_i == DivStart) && !bus.annul_i;

    // Next-state and next-output logic
    always_comb begin
        // NOTE: every signal assigned here gets a default first; any path
        // that left one unassigned would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        sign_d    = sign_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            DivFree: begin
                if (accept) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d             = DivOn;
                        sign_d.signed_mode  = bus.signed_div_i;
                        sign_d.dividend_neg = bus.opdata1_i[31];
                        sign_d.divisor_neg  = bus.opdata2_i[31];
                        divisor_d           = magnitude(bus.opdata2_i, bus.signed_div_i);
                        work_d              = {32'b0, magnitude(bus.opdata1_i, bus.signed_div_i), 1'b0};
                        cnt_d               = '0;
                    end
                end
            end

            DivByZero: begin
                state_d  = DivEnd;
                result_d = '0;
                ready_d  = DivResultReady;
            end

            DivOn: begin
                if (bus.annul_i) begin
                    // Flushed instruction: drop the partial result silently
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else if (cnt_q < DivIterations) begin
                    if (trial[32]) begin
                        work_d = {work_q[63:0], 1'b0};
                    end else begin
                        work_d = {trial[31:0], work_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = DivEnd;
                    result_d = {remainder_fix, quotient_fix};
                    ready_d  = DivResultReady;
                end
            end

            DivEnd: begin
                // Hold the result until EX lowers its request; annul is ignored
                if (bus.start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end

            default: begin
                state_d  = DivFree;
                result_d = '0;
                ready_d  = DivResultNotReady;
            end
        endcase
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so update order inside the block is irrelevant.
        if (rst) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        // NOTE: these carry no reset; they are fully loaded on every accepted
        // divide and are never observed outside the ON state.
        work_q    <= work_d;
        divisor_q <= divisor_d;
        sign_q    <= sign_d;
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: unsigned/signed divides,
// divide-by-zero, signed overflow, annul, mid-operation reset and result hold.
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic rose;

    always #5 clk = ~clk;

    div_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
    endtask

    // Count edges from the request until ready_o is seen; operands are
    // scrambled after the sampling edge since they must not matter any more.
    task automatic wait_ready(input string tag, input int exp_lat);
        int k;
        k = 0;
        do begin
            tick();
            k++;
            if (k == 1) begin
                bus.opdata1_i = $urandom;
                bus.opdata2_i = $urandom;
            end
        end while (bus.ready_o !== 1'b1 && k < 200);
        check64({tag, " ready"}, 64'(bus.ready_o), 64'd1);
        check64({tag, " latency"}, 64'(k), 64'(exp_lat));
    endtask

    task automatic finish_div(input string tag);
        bus.start_i = 1'b0;
        tick();
        check64({tag, " ready_clear"}, 64'(bus.ready_o), 64'd0);
        check64({tag, " result_clear"}, bus.result_o, 64'd0);
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
        launch(sgn, a, b);
        wait_ready(tag, exp_lat);
        check64({tag, " result"}, bus.result_o, exp_res);
    endtask

    initial begin
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        tick();
        tick();
        check64("reset ready", 64'(bus.ready_o), 64'd0);
        check64("reset result", bus.result_o, 64'd0);
        rst = 1'b0;
        tick();

        // Unsigned 100/7 = 14 rem 2
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
        finish_div("divu_100_7");

        // Signed -7/2 = -3 rem -1; 7/-2 = -3 rem 1
        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
        finish_div("div_m7_2");
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
        finish_div("div_7_m2");

        // Divide by zero in both modes
        run_div("divu_by0", 1'b0, 32'd5, 32'd0, 64'h0, 2);
        finish_div("divu_by0");
        run_div("div_by0", 1'b1, 32'd5, 32'd0, 64'h0, 2);
        finish_div("div_by0");

        // Signed overflow and the same operands unsigned
        run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
        finish_div("div_ovf");
        run_div("divu_ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 34);
        finish_div("divu_ovf");

        // Annul while cnt=10, then a fresh start the next cycle
        rose = 1'b0;
        launch(1'b0, 32'h12345678, 32'd3);
        tick();
        repeat (10) begin
            tick();
            rose |= bus.ready_o;
        end
        bus.annul_i = 1'b1;
        tick();
        rose |= bus.ready_o;
        check64("annul ready_low", 64'(bus.ready_o), 64'd0);
        check64("annul result_zero", bus.result_o, 64'd0);
        check64("annul never_ready", 64'(rose), 64'd0);
        bus.annul_i   = 1'b0;
        bus.opdata1_i = 32'h10;
        bus.opdata2_i = 32'h4;
        wait_ready("annul_restart", 34);
        check64("annul_restart result", bus.result_o, 64'h00000000_00000004);
        finish_div("annul_restart");

        // Reset in the middle of ON: must come back idle and never complete
        launch(1'b0, 32'd1000, 32'd10);
        repeat (6) tick();
        rst         = 1'b1;
        bus.start_i = 1'b0;
        tick();
        rst = 1'b0;
        check64("midreset ready", 64'(bus.ready_o), 64'd0);
        check64("midreset result", bus.result_o, 64'd0);
        rose = 1'b0;
        repeat (40) begin
            tick();
            rose |= bus.ready_o;
        end
        check64("midreset no_complete", 64'(rose), 64'd0);

        // Full divide after reset, then hold in END with changed operands
        run_div("divu_1000_10", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 34);
        bus.opdata1_i = 32'hDEADBEEF;
        rose = 1'b1;
        repeat (20) begin
            tick();
            rose &= bus.ready_o;
        end
        check64("hold ready", 64'(rose), 64'd1);
        check64("hold result", bus.result_o, 64'h00000000_00000064);
        finish_div("hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the MIPS32 core's DIV/DIVU instructions. It sits beside the execute stage. EX forwards the operands and a start request, then stalls the pipeline until `ready_o` is high. The 64-bit result (remainder in the high word, quotient in the low word) goes back to EX, which writes it to HI/LO through the normal `whilo` path. The algorithm is radix-2 restoring division, one quotient bit per cycle.

## Interface
- No parameters. The width is fixed at 32 bits, and `RegBus`/`DoubleRegBus` are taken from the shared defines.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `signed_div_i` in 1: 1 selects DIV (two's-complement operands); 0 selects DIVU.
- `opdata1_i` in 32: dividend.
- `opdata2_i` in 32: divisor.
- `start_i` in 1: divide request from EX; held high until EX observes `ready_o`.
- `annul_i` in 1: cancel an in-flight divide (flush of the owning instruction).
- `result_o` out 64: {remainder, quotient}.
- `ready_o` out 1: `result_o` is valid.

## Operation
- State machine with four states: IDLE, BYZERO, ON, END. All outputs are registered.
- **IDLE**
  - If `start_i`=1, `annul_i`=0 and `opdata2_i`=0: go to BYZERO.
  - If `start_i`=1, `annul_i`=0 and `opdata2_i`≠0: go to ON.
    - Latch magnitudes. For signed mode, an operand with bit 31 set is replaced by ~x+1; 0x80000000 maps to itself, treated as unsigned.
    - Latch `signed_div_i` and both operand sign bits.
    - Clear the 6-bit iteration counter `cnt`.
    - Load the 65-bit working register as {32'b0, |dividend|, 1'b0}.
  - Otherwise stay in IDLE.
- **BYZERO**: next state END with result 0.
- **ON**
  - If `annul_i`=1: go to IDLE immediately. `ready_o` stays 0 and the result is discarded.
  - Else if `cnt`<32, run one iteration and increment `cnt`:
    - Trial = work[63:32] − |divisor|, at 33-bit width.
    - If the trial is negative: work <= {work[63:0], 1'b0}.
    - Else: work <= {trial[31:0], work[31:0], 1'b1}.
  - Else (`cnt`=32), finish and go to END:
    - quotient = work[31:0]; remainder = work[64:33].
    - Sign correction, signed mode only:
      - Negate the quotient if the operand signs differ.
      - Negate the remainder if the dividend was negative.
    - This gives truncate-toward-zero semantics, with the remainder taking the sign of the dividend.
- **END**
  - `ready_o`=1 and `result_o` holds the value.
  - Stay in END while `start_i`=1.
  - When `start_i`=0: go to IDLE, and clear `ready_o` and `result_o` to 0 at the same edge.
  - `annul_i` is ignored in END.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0. No trap.
- `start_i` dropping during ON is ignored; only `annul_i` cancels a divide.

## Timing
- On reset, synchronously: state = IDLE, `ready_o`=0, `result_o`=0, `cnt`=0. This applies from any state, including mid-ON.
- Let N be the cycle in which IDLE samples the start:
  - Normal divide: iterations run in cycles N+1..N+32, correction happens in cycle N+33, and `ready_o` first goes high in cycle N+34.
  - Divide by zero: `ready_o` first goes high in cycle N+2.
- `ready_o` stays high until the cycle after `start_i` falls. `result_o` is stable for that whole window.
- A new start can be accepted in the first IDLE cycle after END, so back-to-back divides run with no extra bubble.
- Operand inputs are sampled only in IDLE and may change afterward.

## Structure
- Add these to the shared defines file:
  - State encodings: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
  - `DivStart`/`DivStop` and `DivResultReady`/`DivResultNotReady` constants.
- No sub-module: a single `div_unit` file.
- EX gains the ports to drive `start_i`, the operands and `signed_div_i`, and to consume `result_o`/`ready_o`. Those EX changes are outside this block.

## Test plan
- **Unsigned divide:** DIVU 100/7 → `result_o`=0x00000002_0000000E, `ready_o` first high at N+34.
- **Signed divide:** DIV 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; and 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- **Divide by zero:** 5/0 in either mode → `result_o`=0, `ready_o` at N+2; then drop `start_i` → `ready_o`=0 next cycle.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF signed → 0x00000000_80000000; the same operands unsigned → quotient 0, remainder 0x80000000.
- **Annul:** assert `annul_i` at `cnt`=10 → IDLE next cycle, `ready_o` never rises; a fresh start the following cycle completes 0x10/4 → 0x00000000_00000004.
- **Reset mid-operation:** assert `rst` during ON → IDLE with zero outputs next cycle; `start_i` held high in END with a changed `opdata1_i` → the result is held, with no restart.
